ov7670_sccb_config: RTL and testbench
=====================================

OV7670_SCCB_CONFIG -- requirements
Module: ov7670_sccb_config

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000: frequency of clk in Hz.
REQ-002 Parameter SCCB_HZ, default 100_000: SIO_C bit rate in Hz.
REQ-003 Parameter DEV_ID, default 8'h42: 8-bit SCCB write ID; the read ID is DEV_ID|1.
REQ-004 Parameter RESET_WAIT_CYC, default 50_000: number of clk cycles to wait after a soft-reset write.
REQ-005 clk  input  1  the single clock (50 MHz board clock); all logic is on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  one-cycle pulse that begins the configuration sequence.
REQ-008 busy  output  1  high while the sequence runs.
REQ-009 done  output  1  high (sticky) once the table has been written completely.
REQ-010 error  output  1  sticky readback-mismatch flag; tied to 0 when the readback feature is off.
REQ-011 entry_idx  output  8  index of the table entry currently being written.
REQ-012 sioc  output  1  SCCB clock.
REQ-013 siod_oe  output  1  when 1, the open-drain pad drives SIO_D low; when 0, SIO_D is released.
REQ-014 siod_i  input  1  sampled SIO_D pad value.

Function
REQ-015 Each table entry is {reg_addr[7:0], reg_data[7:0]}; the table ends at the first entry equal to 16'hFFFF; it holds at most 255 entries.
REQ-016 Sequencer states: IDLE, FETCH, XFER, XWAIT, RST_WAIT, (VERIFY), DONE, ERROR.
- IDLE goes to FETCH when start is high.
- FETCH goes to DONE on the end marker, otherwise to XFER.
- XFER starts the engine and goes to XWAIT.
- XWAIT leaves when the engine is not busy.
REQ-017 After an entry with reg_addr=8'h12 and reg_data[7]=1 completes, the sequencer SHALL wait exactly RESET_WAIT_CYC cycles in RST_WAIT before the next FETCH.
REQ-018 Entries SHALL be written in index order; entry_idx increments by 1 per completed entry.
REQ-019 The write transaction is a 3-phase write:
- START, DEV_ID, reg_addr, reg_data, STOP.
- Each phase is 8 data bits MSB-first plus a 9th don't-care bit with SIO_D released.
REQ-020 Bit timing: quarter-period tick = CLK_HZ/(4*SCCB_HZ) cycles (125 at the defaults).
- SIO_D changes only while sioc is low; sioc is high for 2 quarters per bit.
REQ-021 START: SIO_D falls while sioc is high. STOP: SIO_D rises while sioc is high. At least 2 quarters of bus idle between transactions.
REQ-022 busy=1 from the cycle after start is accepted until the cycle DONE (or ERROR) is entered.
- done asserts in the same cycle DONE is entered.
REQ-023 start while busy=1 SHALL be ignored.
REQ-024 start in DONE or ERROR SHALL clear done and error and restart from entry 0.
REQ-025 An end marker at entry 0 SHALL produce done=1 within 3 cycles with no bus activity.
REQ-026 When idle, sioc=1 and siod_oe=0.

Reset
REQ-027 Reset (asynchronous) SHALL force the following, even mid-transaction, with no STOP generated:
- state=IDLE, entry_idx=0;
- busy=0, done=0, error=0;
- sioc=1, siod_oe=0;
- all counters to 0.
REQ-028 After reset is released, the block SHALL remain in IDLE until the next start.

Configuration
REQ-029 Macro SCCB_READBACK_EN, when defined, enables read-back verification:
- After each write, the block performs a 2-phase write (DEV_ID, reg_addr) + STOP, then a 2-phase read (DEV_ID|1, 8 bits sampled at the sioc high midpoint, NA bit=1) + STOP.
- A mismatch with reg_data sets error=1 and enters ERROR (busy=0, done=0).
- The reg_addr=8'h12 entry is exempt from read-back.
REQ-030 When SCCB_READBACK_EN is undefined, the VERIFY state and read path SHALL be absent, siod_i is unused, and error is constant 0.

Structure
REQ-031 A shared package ov7670_cfg_pkg SHALL hold:
- the state enum;
- the END_MARKER constant (16'hFFFF);
- the soft-reset constants (8'h12, bit 7);
- the configuration table as a constant array and its lookup function.
REQ-032 One sub-module, sccb_master, SHALL be the byte-phase engine:
- inputs: start, phase count, bytes, read flag;
- outputs: busy, rdata, sioc, siod_oe.
- The sequencer contains no bit timing.

Verification
REQ-033 Table {12/80, 11/01, FFFF}, start pulse:
- bus decodes writes 42-12-80, then 42-11-01;
- gap between the two STOPs is at least RESET_WAIT_CYC cycles;
- done=1, entry_idx=2.
REQ-034 At the defaults, sioc period is 500 clk cycles, and siod_oe never changes while sioc=1 except at START and STOP.
REQ-035 Assert reset during the second phase of a transaction:
- sioc=1, siod_oe=0, busy=0 asynchronously;
- a subsequent start re-writes from entry 0.
REQ-036 Second start pulse during busy: ignored, no duplicate transaction. Table {FFFF}: done=1 within 3 cycles, sioc held at 1.
REQ-037 With SCCB_READBACK_EN defined, a slave model returns 8'h00 for register 8'h11 (written 8'h01): error=1, busy=0, done=0, no further entries written.

Source files
------------

// File: rtl/ov7670_sccb_config_pkg.sv
// Shared sequencer encoding, soft-reset constants and the OV7670 register table.
package ov7670_cfg_pkg;

   typedef logic [2:0] seq_state_t;
   localparam seq_state_t S_IDLE     = 3'd0;
   localparam seq_state_t S_FETCH    = 3'd1;
   localparam seq_state_t S_XFER     = 3'd2;
   localparam seq_state_t S_XWAIT    = 3'd3;
   localparam seq_state_t S_RST_WAIT = 3'd4;
   localparam seq_state_t S_VERIFY   = 3'd5;
   localparam seq_state_t S_DONE     = 3'd6;
   localparam seq_state_t S_ERROR    = 3'd7;

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] data;
   } cfg_entry_t;

   localparam logic [15:0] END_MARKER = 16'hFFFF;
   localparam logic [7:0]  SRST_ADDR  = 8'h12;
   localparam int          SRST_BIT   = 7;

   // COM7 soft reset first, then CLKRC prescaler; padded with end markers.
   localparam int CFG_AW  = 2;
   localparam int CFG_LEN = 1 << CFG_AW;
   localparam logic [15:0] CFG_TABLE [CFG_LEN] = '{16'h1280, 16'h1101, END_MARKER, END_MARKER};

   // sel=1 selects the empty table (end marker only).
   function automatic cfg_entry_t cfg_lookup(input logic sel, input logic [7:0] idx);
      cfg_entry_t e;
      e = END_MARKER;
      if (!sel && idx < 8'(CFG_LEN)) e = CFG_TABLE[idx[CFG_AW-1:0]];
      return e;
   endfunction

   function automatic logic is_soft_reset(input cfg_entry_t e);
      return (e.addr == SRST_ADDR) && e.data[SRST_BIT];
   endfunction

endpackage

// File: rtl/ov7670_sccb_config_if.sv
// Host/pad-side signal bundle of the SCCB configurator.
interface ov7670_sccb_config_if;
   logic       start;
   logic       busy;
   logic       done;
   logic       error;
   logic [7:0] entry_idx;
   logic       sioc;
   logic       siod_oe;
   logic       siod_i;

   modport master (output start, siod_i,
                   input  busy, done, error, entry_idx, sioc, siod_oe);
   modport slave  (input  start, siod_i,
                   output busy, done, error, entry_idx, sioc, siod_oe);
endinterface

// File: rtl/ov7670_sccb_config_sccb_master.sv
// SCCB byte-phase engine: START, 1..3 nine-bit phases (last one optionally read), STOP, idle gap.
module sccb_master #(
   parameter int TICK = 125
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [1:0]      nphase,
   input  logic [2:0][7:0] bytes,
   input  logic            rd,
   input  logic            siod_i,
   output logic            busy,
   output logic [7:0]      rdata,
   output logic            sioc,
   output logic            siod_oe
);

   localparam logic [1:0] E_IDLE = 2'd0, E_START = 2'd1, E_BIT = 2'd2, E_STOP = 2'd3;
   localparam int TW = (TICK > 1) ? $clog2(TICK) : 1;

   logic [1:0]      st;
   logic [TW-1:0]   tcnt;
   logic [2:0]      q;
   logic [3:0]      bitn;
   logic [1:0]      ph, nph;
   logic [2:0][7:0] b;
   logic            rdq, rd_phase, qend;
   logic [7:0]      sh, rsh;
   logic            sioc_c, oe_c;

   assign qend     = tcnt == TW'(TICK - 1);
   assign rd_phase = rdq && (ph == nph - 2'd1);
   assign busy     = st != E_IDLE;
   assign rdata    = rsh;

   // Bit = 4 quarters: low (data set up), high, high (sample at mid), low.
   always_comb begin
      sioc_c = 1'b1;
      oe_c   = 1'b0;
      case (st)
         E_START: begin
            sioc_c = (q != 3'd2);
            oe_c   = (q != 3'd0);
         end
         E_BIT: begin
            sioc_c = (q == 3'd1) || (q == 3'd2);
            oe_c   = (bitn < 4'd8) && !rd_phase && !sh[7];
         end
         E_STOP: begin
            sioc_c = (q != 3'd0);
            oe_c   = (q <= 3'd1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st      <= E_IDLE;
         tcnt    <= '0;
         q       <= '0;
         bitn    <= '0;
         ph      <= '0;
         nph     <= '0;
         b       <= '0;
         rdq     <= 1'b0;
         sh      <= '0;
         rsh     <= '0;
         sioc    <= 1'b1;
         siod_oe <= 1'b0;
      end else begin
         sioc    <= sioc_c;
         siod_oe <= oe_c;
         if (st == E_IDLE) begin
            if (start) begin
               b    <= bytes;
               nph  <= nphase;
               rdq  <= rd;
               rsh  <= '0;
               tcnt <= '0;
               q    <= '0;
               st   <= E_START;
            end
         end else begin
            tcnt <= qend ? '0 : tcnt + TW'(1);
            if (qend) begin
               case (st)
                  E_START: begin
                     if (q == 3'd2) begin
                        st   <= E_BIT;
                        q    <= '0;
                        bitn <= '0;
                        ph   <= '0;
                        sh   <= b[0];
                     end else q <= q + 3'd1;
                  end
                  E_BIT: begin
                     if (q == 3'd1 && rd_phase && bitn < 4'd8) rsh <= {rsh[6:0], siod_i};
                     if (q == 3'd3) begin
                        q <= '0;
                        if (bitn == 4'd8) begin
                           if (ph == nph - 2'd1) st <= E_STOP;
                           else begin
                              ph   <= ph + 2'd1;
                              bitn <= '0;
                              sh   <= b[ph + 2'd1];
                           end
                        end else begin
                           bitn <= bitn + 4'd1;
                           sh   <= {sh[6:0], 1'b0};
                        end
                     end else q <= q + 3'd1;
                  end
                  E_STOP: begin
                     // q3/q4 are the idle gap before the next transaction.
                     if (q == 3'd4) begin
                        st <= E_IDLE;
                        q  <= '0;
                     end else q <= q + 3'd1;
                  end
                  default: st <= E_IDLE;
               endcase
            end
         end
      end
   end

endmodule

// File: rtl/ov7670_sccb_config.sv
// OV7670 register-table sequencer over SCCB. Optional SCCB_READBACK_EN adds read-back verification.
module ov7670_sccb_config
   import ov7670_cfg_pkg::*;
#(
   parameter int         CLK_HZ         = 50_000_000,
   parameter int         SCCB_HZ        = 100_000,
   parameter logic [7:0] DEV_ID         = 8'h42,
   parameter int         RESET_WAIT_CYC = 50_000,
   parameter bit         TABLE_SEL      = 1'b0
) (
   input logic                 clk,
   input logic                 reset,
   ov7670_sccb_config_if.slave bus
);

   localparam int TICK_RAW = CLK_HZ / (4 * SCCB_HZ);
   localparam int TICK     = (TICK_RAW < 1) ? 1 : TICK_RAW;
   localparam int WW       = (RESET_WAIT_CYC > 1) ? $clog2(RESET_WAIT_CYC) : 1;

   seq_state_t      state;
   logic [7:0]      idx;
   logic [WW-1:0]   wcnt;
   cfg_entry_t      cur;
   logic            last;
   logic            eng_start, eng_busy, eng_rd, sda_s;
   logic [1:0]      eng_nph;
   logic [2:0][7:0] eng_bytes;
   logic [7:0]      eng_rdata;

   assign cur  = cfg_lookup(TABLE_SEL, idx);
   assign last = (cur == END_MARKER) || (idx == 8'hFF);

   assign bus.busy      = (state != S_IDLE) && (state != S_DONE) && (state != S_ERROR);
   assign bus.done      = state == S_DONE;
   assign bus.entry_idx = idx;

`ifdef SCCB_READBACK_EN
   logic [1:0] vstep;
   logic [1:0] sda_sync;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) sda_sync <= 2'b11;
      else       sda_sync <= {sda_sync[0], bus.siod_i};
   end
   assign sda_s     = sda_sync[1];
   assign bus.error = state == S_ERROR;
`else
   logic unused_rdata;
   assign unused_rdata = ^eng_rdata;
   assign sda_s        = 1'b1;
   assign bus.error    = 1'b0;
`endif

   always_comb begin
      eng_start = (state == S_XFER);
      eng_nph   = 2'd3;
      eng_bytes = {cur.data, cur.addr, DEV_ID};
      eng_rd    = 1'b0;
`ifdef SCCB_READBACK_EN
      // Read-back: address-set write, then a separate read transaction.
      if (state == S_VERIFY) begin
         eng_start = (vstep == 2'd0) || (vstep == 2'd2);
         eng_nph   = 2'd2;
         if (vstep[1]) begin
            eng_bytes = {8'h00, 8'h00, DEV_ID | 8'h01};
            eng_rd    = 1'b1;
         end else eng_bytes = {8'h00, cur.addr, DEV_ID};
      end
`endif
   end

   sccb_master #(.TICK(TICK)) u_eng (
      .clk     (clk),
      .reset   (reset),
      .start   (eng_start),
      .nphase  (eng_nph),
      .bytes   (eng_bytes),
      .rd      (eng_rd),
      .siod_i  (sda_s),
      .busy    (eng_busy),
      .rdata   (eng_rdata),
      .sioc    (bus.sioc),
      .siod_oe (bus.siod_oe)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
         idx   <= '0;
         wcnt  <= '0;
`ifdef SCCB_READBACK_EN
         vstep <= '0;
`endif
      end else begin
         case (state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (bus.start) begin
                  state <= S_FETCH;
                  idx   <= '0;
               end
            end
            S_FETCH: state <= last ? S_DONE : S_XFER;
            S_XFER:  state <= S_XWAIT;
            S_XWAIT: begin
               if (!eng_busy) begin
                  if (is_soft_reset(cur)) begin
                     state <= S_RST_WAIT;
                     wcnt  <= '0;
                  end else begin
`ifdef SCCB_READBACK_EN
                     state <= S_VERIFY;
                     vstep <= '0;
`else
                     idx   <= idx + 8'd1;
                     state <= S_FETCH;
`endif
                  end
               end
            end
            S_RST_WAIT: begin
               // Sensor ignores SCCB while its soft reset settles.
               if (wcnt == WW'(RESET_WAIT_CYC - 1)) begin
                  wcnt  <= '0;
                  idx   <= idx + 8'd1;
                  state <= S_FETCH;
               end else wcnt <= wcnt + WW'(1);
            end
`ifdef SCCB_READBACK_EN
            S_VERIFY: begin
               case (vstep)
                  2'd0, 2'd2: vstep <= vstep + 2'd1;
                  2'd1: if (!eng_busy) vstep <= 2'd2;
                  default: begin
                     if (!eng_busy) begin
                        vstep <= '0;
                        if (eng_rdata != cur.data) state <= S_ERROR;
                        else begin
                           idx   <= idx + 8'd1;
                           state <= S_FETCH;
                        end
                     end
                  end
               endcase
            end
`endif
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ov7670_sccb_config.sv
// Directed bench: decodes the SCCB bus of a fast-timed instance, plus default-timing and empty-table instances.
module tb_ov7670_sccb_config;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ov7670_sccb_config_if bf ();
   ov7670_sccb_config_if bd ();
   ov7670_sccb_config_if be ();

   ov7670_sccb_config #(.CLK_HZ(8_000_000), .SCCB_HZ(100_000), .DEV_ID(8'h42),
                        .RESET_WAIT_CYC(3000), .TABLE_SEL(1'b0))
      dut_f (.clk(clk), .reset(rst), .bus(bf));
   ov7670_sccb_config dut_d (.clk(clk), .reset(rst), .bus(bd));
   ov7670_sccb_config #(.CLK_HZ(8_000_000), .SCCB_HZ(100_000), .DEV_ID(8'h42),
                        .RESET_WAIT_CYC(3000), .TABLE_SEL(1'b1))
      dut_e (.clk(clk), .reset(rst), .bus(be));

   logic slv_low = 1'b0;
   assign bf.siod_i = ~bf.siod_oe & ~slv_low;
   assign bd.siod_i = ~bd.siod_oe;
   assign be.siod_i = ~be.siod_oe;

   int n_chk = 0, n_fail = 0;
   longint cyc = 0;
   initial forever begin @(posedge clk); cyc++; end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Bus decoder / slave model on the fast instance.
   logic [31:0] tx_q[$];
   longint      stop_q[$];
   bit          prev_scl = 1, prev_sda = 1, prev_oe = 0, in_x = 0, rdm = 0;
   int          bitn = 0, nb = 0, n_start = 0, n_stop = 0, n_oe_hi = 0, n_illegal = 0;
   logic [7:0]  cb [3];
   logic [7:0]  sh = 8'h00;
`ifdef SCCB_READBACK_EN
   logic [7:0]  mem [256];
   logic [7:0]  last_addr = 8'h00;
   logic [7:0]  rbyte;
`endif

   initial forever begin
      @(negedge clk);
      if (rst) begin
         in_x = 0; slv_low = 0;
      end else begin
         if (bf.sioc && prev_scl && bf.siod_oe != prev_oe) n_oe_hi++;
         if (bf.sioc && prev_scl && prev_sda && !bf.siod_i) begin
            if (in_x) n_illegal++;
            n_start++; in_x = 1; bitn = 0; nb = 0; rdm = 0;
            cb[0] = 0; cb[1] = 0; cb[2] = 0;
         end else if (bf.sioc && prev_scl && !prev_sda && bf.siod_i) begin
            n_stop++;
            if (in_x) begin
               tx_q.push_back({8'(nb), cb[0], cb[1], cb[2]});
               stop_q.push_back(cyc);
`ifdef SCCB_READBACK_EN
               if (nb == 3 && !cb[0][0]) mem[cb[1]] = cb[2];
               if (nb == 2 && !cb[0][0]) last_addr = cb[1];
`endif
            end
            in_x = 0;
         end else if (in_x && bf.sioc && !prev_scl) begin
            if (bitn < 8) sh = {sh[6:0], bf.siod_i};
            bitn++;
            if (bitn == 9) begin
               if (nb < 3) cb[nb] = sh;
               if (nb == 0) rdm = sh[0];
               nb++; bitn = 0;
            end
         end else if (in_x && !bf.sioc && prev_scl) begin
`ifdef SCCB_READBACK_EN
            rbyte   = (last_addr == 8'h11) ? 8'h00 : mem[last_addr];
            slv_low = rdm && nb == 1 && bitn < 8 && !rbyte[7 - bitn];
`endif
         end
         if (!in_x) slv_low = 0;
      end
      prev_scl = bf.sioc; prev_sda = bf.siod_i; prev_oe = bf.siod_oe;
   end

   task automatic pulse(input int which);
      @(posedge clk); #1;
      case (which) 0: bf.start = 1; 1: bd.start = 1; default: be.start = 1; endcase
      @(posedge clk); #1;
      bf.start = 0; bd.start = 0; be.start = 0;
   endtask

   task automatic wait_end(input string tag, input int budget);
      int t;
      t = 0;
      while (!(bf.done || bf.error) && t < budget) begin @(negedge clk); t++; end
      check(tag, bf.done || bf.error, 1);
   endtask

   task automatic wait_stops(input string tag, input int n, input int budget);
      int t;
      t = 0;
      while (stop_q.size() < n && t < budget) begin @(negedge clk); t++; end
      check(tag, stop_q.size() >= n, 1);
   endtask

   initial begin : main
      int base, t, k, hw, got;
      int e [3];
      bit p, bad;
      bf.start = 0; bd.start = 0; be.start = 0;
      repeat (3) @(negedge clk);
      check("rst_sioc", bf.sioc, 1);
      check("rst_oe", bf.siod_oe, 0);
      check("rst_busy", bf.busy, 0);
      check("rst_done", bf.done, 0);
      check("rst_err", bf.error, 0);
      check("rst_idx", bf.entry_idx, 0);
      @(posedge clk); #1 rst = 0;

      // Default timing: 500-cycle sioc period, high for 250.
      pulse(1);
      k = 0; t = 0; hw = 0; p = bd.sioc;
      while (k < 3 && t < 3000) begin
         @(negedge clk); t++;
         if (bd.sioc && !p) begin e[k] = t; k++; end
         if (!bd.sioc && p && k == 1 && hw == 0) hw = t - e[0];
         p = bd.sioc;
      end
      check("dflt_edges", k, 3);
      check("dflt_period0", e[1] - e[0], 500);
      check("dflt_period1", e[2] - e[1], 500);
      check("dflt_high", hw, 250);

      // Empty table.
      pulse(2);
      got = 0; bad = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (be.sioc !== 1'b1 || be.siod_oe !== 1'b0) bad = 1;
         if (be.done && got == 0) got = i + 1;
      end
      check("empty_done", be.done, 1);
      check("empty_lat", (got > 0) && (got <= 3), 1);
      check("empty_bus", bad, 0);
      check("empty_busy", be.busy, 0);

      // Full table on the fast instance.
      base = tx_q.size();
      pulse(0);
      @(negedge clk);
      check("t1_busy", bf.busy, 1);
      wait_stops("t1_stop1", base + 1, 6000);
      check("t1_idx_wait", bf.entry_idx, 0);
      check("t1_busy_wait", bf.busy, 1);
      wait_end("t1_end", 20000);
      check("t1_tx0", tx_q[base], 32'h03_42_12_80);
      check("t1_tx1", tx_q[base + 1], 32'h03_42_11_01);
      check("t1_gap", (stop_q[base + 1] - stop_q[base]) >= 3000, 1);
      check("t1_busy_end", bf.busy, 0);
`ifdef SCCB_READBACK_EN
      check("rb_ntx", tx_q.size() - base, 4);
      check("rb_tx2", tx_q[base + 2], 32'h02_42_11_00);
      check("rb_tx3", tx_q[base + 3], 32'h02_43_00_00);
      check("rb_err", bf.error, 1);
      check("rb_done", bf.done, 0);
      check("rb_idx", bf.entry_idx, 1);
      repeat (300) @(negedge clk);
      check("rb_no_more", tx_q.size() - base, 4);
`else
      check("t1_ntx", tx_q.size() - base, 2);
      check("t1_done", bf.done, 1);
      check("t1_err", bf.error, 0);
      check("t1_idx", bf.entry_idx, 2);

      // Restart from DONE, then reset during the reg_addr phase.
      pulse(0);
      @(negedge clk);
      check("t2_done_clr", bf.done, 0);
      check("t2_busy", bf.busy, 1);
      t = 0;
      while (!(in_x && nb == 1 && bitn >= 2) && t < 3000) begin @(negedge clk); t++; end
      check("t2_phase2", in_x && nb == 1, 1);
      #2 rst = 1;
      #1;
      check("t2_rst_sioc", bf.sioc, 1);
      check("t2_rst_oe", bf.siod_oe, 0);
      check("t2_rst_busy", bf.busy, 0);
      repeat (3) @(negedge clk);
      @(posedge clk); #1 rst = 0;
      k = n_start;
      repeat (200) @(negedge clk);
      check("t2_idle_start", n_start - k, 0);
      check("t2_idle_busy", bf.busy, 0);
      check("t2_idle_sioc", bf.sioc, 1);
      check("t2_idle_idx", bf.entry_idx, 0);

      // Restart after reset with extra start pulses while busy.
      base = tx_q.size();
      pulse(0);
      repeat (300) @(negedge clk);
      pulse(0);
      repeat (3000) @(negedge clk);
      pulse(0);
      wait_end("t3_end", 20000);
      check("t3_ntx", tx_q.size() - base, 2);
      check("t3_tx0", tx_q[base], 32'h03_42_12_80);
      check("t3_tx1", tx_q[base + 1], 32'h03_42_11_01);
      check("t3_done", bf.done, 1);
      check("t3_idx", bf.entry_idx, 2);
`endif
      check("bus_illegal", n_illegal, 0);
      check("oe_hi_only_start_stop", n_oe_hi, n_start + n_stop);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
